// File: rtl/csel_subtractor_seq.sv
// Multi-cycle borrow-select subtractor: diff = a - b, BLOCK bits per cycle, LSB chunk first.
// Optional zero flag output enabled by defining CSEL_SUB_ZERO_FLAG_EN.
module csel_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
`ifdef CSEL_SUB_ZERO_FLAG_EN
    output logic             overflow,
    output logic             zero
`else
    output logic             overflow
`endif
);

    localparam int N  = WIDTH / BLOCK;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N);

    generate
        if (WIDTH % BLOCK != 0) begin : g_bad_block
            $error("csel_subtractor_seq: WIDTH must be a multiple of BLOCK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt_reg;
    logic             run_borrow_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             overflow_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
`ifdef CSEL_SUB_ZERO_FLAG_EN
    logic             nz_reg;
    logic             zero_reg;
`endif

    // Operand chunks as arrays so the active chunk is a simple indexed select.
    logic [BLOCK-1:0] a_chunks [N];
    logic [BLOCK-1:0] b_chunks [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            assign a_chunks[gi] = a_reg[gi*BLOCK +: BLOCK];
            assign b_chunks[gi] = b_reg[gi*BLOCK +: BLOCK];
        end
    endgenerate

    logic [IW-1:0]  idx;
    logic [BLOCK:0] d0_next;
    logic [BLOCK:0] d1_next;
    logic [BLOCK:0] sel_next;

    always_comb begin
        idx      = cnt_reg[IW-1:0];
        d0_next  = {1'b0, a_chunks[idx]} - {1'b0, b_chunks[idx]};
        d1_next  = d0_next - {{BLOCK{1'b0}}, 1'b1};
        sel_next = run_borrow_reg ? d1_next : d0_next;
    end

    // Chunks complete on edges 1..N after accept; the extra edge derives the flags from the full diff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            cnt_reg        <= '0;
            run_borrow_reg <= 1'b0;
            diff_reg       <= '0;
            borrow_reg     <= 1'b0;
            overflow_reg   <= 1'b0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
`ifdef CSEL_SUB_ZERO_FLAG_EN
            nz_reg         <= 1'b0;
            zero_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg          <= a;
                        b_reg          <= b;
                        cnt_reg        <= '0;
                        run_borrow_reg <= 1'b0;
`ifdef CSEL_SUB_ZERO_FLAG_EN
                        nz_reg         <= 1'b0;
`endif
                        in_ready_reg   <= 1'b0;
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg != LAST) begin
                        for (int k = 0; k < N; k++) begin
                            if (idx == IW'(k)) begin
                                diff_reg[k*BLOCK +: BLOCK] <= sel_next[BLOCK-1:0];
                            end
                        end
                        run_borrow_reg <= sel_next[BLOCK];
`ifdef CSEL_SUB_ZERO_FLAG_EN
                        nz_reg         <= nz_reg | (|sel_next[BLOCK-1:0]);
`endif
                        cnt_reg        <= cnt_reg + 1'b1;
                    end else begin
                        borrow_reg    <= run_borrow_reg;
                        overflow_reg  <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                                         (diff_reg[WIDTH-1] ^ a_reg[WIDTH-1]);
`ifdef CSEL_SUB_ZERO_FLAG_EN
                        zero_reg      <= ~nz_reg;
`endif
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;
    assign overflow  = overflow_reg;
`ifdef CSEL_SUB_ZERO_FLAG_EN
    assign zero      = zero_reg;
`endif

endmodule

// File: tb/tb_csel_subtractor_seq.sv
// Self-checking bench for csel_subtractor_seq: directed corner cases plus random operands
// checked against plain integer arithmetic.
module tb_csel_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;
`ifdef CSEL_SUB_ZERO_FLAG_EN
    logic        zero;
`endif

    int checks   = 0;
    int failures = 0;

    csel_subtractor_seq #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
`ifdef CSEL_SUB_ZERO_FLAG_EN
        .overflow  (overflow),
        .zero      (zero)
`else
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input bit pulse_busy, input int hold);
        int          cycles;
        int          sa, sb, sd;
        logic [15:0] exp_diff;
        logic        exp_borrow, exp_ovf;
        logic [15:0] held_diff;
        exp_diff   = 16'((32'(ta) - 32'(tb_v)) & 32'hFFFF);
        exp_borrow = (ta < tb_v);
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        sd = sa - sb;
        exp_ovf = (sd > 32767) || (sd < -32768);

        @(negedge clk);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            if (pulse_busy && cycles == 1) begin
                in_valid = 1'b1;
                a = ~ta;
                b = ta ^ 16'h00F0;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cycles++;
        end
        chk("latency", 32'(cycles), 32'd5);
        chk("diff", 32'(diff), 32'(exp_diff));
        chk("borrow", 32'(borrow), 32'(exp_borrow));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef CSEL_SUB_ZERO_FLAG_EN
        chk("zero", 32'(zero), 32'(exp_diff == 16'h0));
`endif
        $display("op a=0x%04h b=0x%04h diff=0x%04h borrow=%0d ovf=%0d latency=%0d",
                 ta, tb_v, diff, borrow, overflow, cycles);
        held_diff = diff;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_diff", 32'(diff), 32'(held_diff));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
`ifdef CSEL_SUB_ZERO_FLAG_EN
        chk("rst_zero", 32'(zero), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h1234, 16'h0234, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 0);
        do_op(16'h5A5A, 16'h5A5A, 1'b0, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
        do_op(16'hABCD, 16'h1357, 1'b1, 10);

        // Abort mid-operation: reset acts immediately, then a fresh operation completes.
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h4321;
        b = 16'h1111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0F0F, 16'hF0F0, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = (i % 6 == 0) ? ra : 16'($urandom);
            do_op(ra, rb, (i % 5 == 0), (i % 7 == 0) ? 3 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
